// File: rtl/eeg_adc_spi_reader.sv
// EEG ADC SPI frame reader: waits for DRDY, clocks one status word plus
// CHANNELS data words out of the ADC in SPI mode 1, and emits 16-bit samples.
module eeg_adc_spi_reader #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CHANNELS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        drdy_n,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic [2:0]  sample_chan,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] TOTAL_BITS = 8'(24 * (CHANNELS + 1));
    localparam logic [3:0] LAST_WORD  = 4'(CHANNELS);

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_drdy_meta;
    logic        r_drdy_sync;
    logic        r_drdy_prev;

    logic [7:0]  r_div_cnt;
    logic        r_phase_low;
    logic [7:0]  r_bit_cnt;
    logic [4:0]  r_bit_in_word;
    logic [3:0]  r_word_idx;
    logic [22:0] r_shift;

    logic [15:0] r_sample_out;
    logic [2:0]  r_sample_chan;
    logic        r_sample_valid;
    logic        r_frame_done;
    logic        r_overrun;

    logic        w_drdy_fall;
    logic        w_start;
    logic        w_div_last;
    logic        w_sample;
    logic        w_word_end;

    assign w_drdy_fall = r_drdy_prev & ~r_drdy_sync;
    assign w_start     = w_drdy_fall & enable & (r_state == IDLE);
    assign w_div_last  = (r_div_cnt == DIV_LAST);
    assign w_sample    = (r_state == SHIFT) & ~r_phase_low & w_div_last;
    assign w_word_end  = w_sample & (r_bit_in_word == 5'd23);

    // Resynchronise DRDY and keep one extra stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drdy_meta <= 1'b1;
            r_drdy_sync <= 1'b1;
            r_drdy_prev <= 1'b1;
        end else begin
            r_drdy_meta <= drdy_n;
            r_drdy_sync <= r_drdy_meta;
            r_drdy_prev <= r_drdy_sync;
        end
    end

    // Frame sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame sequencer next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (w_div_last) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_div_last && r_phase_low &&
                    (r_bit_cnt == TOTAL_BITS)) begin
                    w_next = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (w_div_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // SCLK phase divider, bit/word counters and MISO shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_phase_low   <= 1'b0;
            r_bit_cnt     <= '0;
            r_bit_in_word <= '0;
            r_word_idx    <= '0;
            r_shift       <= '0;
        end else begin
            if ((r_state == IDLE) || w_div_last) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end

            if (w_start) begin
                r_phase_low   <= 1'b0;
                r_bit_cnt     <= '0;
                r_bit_in_word <= '0;
                r_word_idx    <= '0;
                r_shift       <= '0;
            end else if ((r_state == SHIFT) && w_div_last) begin
                r_phase_low <= ~r_phase_low;
                if (!r_phase_low) begin
                    r_shift   <= {r_shift[21:0], spi_miso};
                    r_bit_cnt <= r_bit_cnt + 8'd1;
                    if (r_bit_in_word == 5'd23) begin
                        r_bit_in_word <= '0;
                        r_word_idx    <= r_word_idx + 4'd1;
                    end else begin
                        r_bit_in_word <= r_bit_in_word + 5'd1;
                    end
                end
            end
        end
    end

    // Sample strobes one cycle after a data word's last bit; overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_out   <= '0;
            r_sample_chan  <= '0;
            r_sample_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overrun      <= w_drdy_fall & (r_state != IDLE);
            if (w_word_end && (r_word_idx != 4'd0)) begin
                // r_shift holds word bits 23..1; the top 16 are the sample
                r_sample_out   <= r_shift[22:7];
                r_sample_chan  <= 3'(r_word_idx - 4'd1);
                r_sample_valid <= 1'b1;
                r_frame_done   <= (r_word_idx == LAST_WORD);
            end
        end
    end

    assign spi_cs_n     = (r_state == IDLE);
    assign spi_sclk     = (r_state == SHIFT) & ~r_phase_low;
    assign sample_out   = r_sample_out;
    assign sample_chan  = r_sample_chan;
    assign sample_valid = r_sample_valid;
    assign frame_done   = r_frame_done;
    assign overrun      = r_overrun;

endmodule
